// File: rtl/snake_frame_timer.sv
// +--------------------------------------------------------------------------+
// | snake_frame_timer                                                        |
// | Frame/stage timing for the snake datapath: draw window, frame tick and   |
// | stage number, with start/pause/game-over control.                        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module snake_frame_timer #(
   parameter int STAGE_W      = 32,
   parameter int CNT_W        = 24,
   parameter int BASE_DELAY   = 1000000,
   parameter int DELAY_STEP   = 50000,
   parameter int MIN_DELAY    = 200000,
   parameter int BLANK_CYCLES = 1,
   parameter int START_STAGE  = 2,
   parameter int NUM_STAGES   = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               pause,
   input  logic               level_up,
   input  logic               game_over,
   output logic [STAGE_W-1:0] rstage,
   output logic               isDrawing,
   output logic               frame_tick,
   output logic [15:0]        frame_count,
   output logic               stage_max
);

   // Window length for a stage; evaluated wide and signed so a large stage
   // can never wrap below the floor.
   function automatic logic [CNT_W-1:0] f_period(input logic [STAGE_W-1:0] s);
      longint v;
      v = longint'(BASE_DELAY)
          - (longint'(s) - longint'(START_STAGE)) * longint'(DELAY_STEP);
      if (v < longint'(MIN_DELAY)) v = longint'(MIN_DELAY);
      return CNT_W'(v);
   endfunction

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_DRAW  = 2'd1;
   localparam logic [1:0] c_BLANK = 2'd2;

   localparam logic [STAGE_W-1:0] c_STAGE_START = STAGE_W'(START_STAGE);
   localparam logic [STAGE_W-1:0] c_STAGE_MAX   = STAGE_W'(START_STAGE + NUM_STAGES - 1);
   localparam logic [CNT_W-1:0]   c_BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0]   c_P0          = f_period(c_STAGE_START);
   localparam logic               c_MAX_AT_START = (NUM_STAGES == 1);

   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_counter;
   logic [CNT_W-1:0]   r_period;
   logic               r_pending;

   logic               w_at_max;
   logic               w_req;
   logic               w_last_draw;
   logic               w_last_blank;
   logic [STAGE_W-1:0] w_next_stage;

   assign w_at_max     = (rstage == c_STAGE_MAX);
   assign w_req        = level_up & ~w_at_max;
   assign w_last_draw  = (r_counter == r_period - CNT_W'(1));
   assign w_last_blank = (r_counter == c_BLANK_LAST);
   // A request arriving on the boundary cycle itself is folded in here.
   assign w_next_stage = ((r_pending | w_req) & ~w_at_max) ? rstage + STAGE_W'(1) : rstage;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= c_IDLE;
         r_counter   <= '0;
         r_period    <= c_P0;
         r_pending   <= 1'b0;
         rstage      <= c_STAGE_START;
         isDrawing   <= 1'b0;
         frame_tick  <= 1'b0;
         frame_count <= 16'd0;
         stage_max   <= c_MAX_AT_START;
      end else if (game_over) begin
         r_state     <= c_IDLE;
         r_counter   <= '0;
         r_period    <= c_P0;
         r_pending   <= 1'b0;
         rstage      <= c_STAGE_START;
         isDrawing   <= 1'b0;
         frame_tick  <= 1'b0;
         frame_count <= 16'd0;
         stage_max   <= c_MAX_AT_START;
      end else begin
         frame_tick <= 1'b0;
         case (r_state)
            c_IDLE: begin
               isDrawing <= 1'b0;
               if (start) begin
                  r_state   <= c_DRAW;
                  r_counter <= '0;
                  isDrawing <= 1'b1;
               end
            end
            c_DRAW, c_BLANK: begin
               if (w_req) r_pending <= 1'b1;
               if (pause) begin
                  isDrawing <= 1'b0;
               end else if (r_state == c_DRAW) begin
                  if (w_last_draw) begin
                     r_state   <= c_BLANK;
                     r_counter <= '0;
                     isDrawing <= 1'b0;
                  end else begin
                     r_counter <= r_counter + CNT_W'(1);
                     isDrawing <= 1'b1;
                  end
               end else begin
                  if (w_last_blank) begin
                     r_state     <= c_DRAW;
                     r_counter   <= '0;
                     isDrawing   <= 1'b1;
                     frame_tick  <= 1'b1;
                     frame_count <= frame_count + 16'd1;
                     rstage      <= w_next_stage;
                     stage_max   <= (w_next_stage == c_STAGE_MAX);
                     r_period    <= f_period(w_next_stage);
                     r_pending   <= 1'b0;
                  end else begin
                     r_counter <= r_counter + CNT_W'(1);
                  end
               end
            end
            default: begin
               r_state   <= c_IDLE;
               r_counter <= '0;
               isDrawing <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_snake_frame_timer.sv
// +--------------------------------------------------------------------------+
// | tb_snake_frame_timer                                                     |
// | Self-checking bench for snake_frame_timer (small timing parameters).     |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_snake_frame_timer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        level_up = 1'b0;
   logic        game_over = 1'b0;
   logic [31:0] rstage;
   logic        isDrawing;
   logic        frame_tick;
   logic [15:0] frame_count;
   logic        stage_max;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   snake_frame_timer #(
      .STAGE_W(32), .CNT_W(24), .BASE_DELAY(10), .DELAY_STEP(2), .MIN_DELAY(5),
      .BLANK_CYCLES(2), .START_STAGE(2), .NUM_STAGES(4)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .pause(pause),
      .level_up(level_up), .game_over(game_over), .rstage(rstage),
      .isDrawing(isDrawing), .frame_tick(frame_tick),
      .frame_count(frame_count), .stage_max(stage_max)
   );

   typedef struct {
      string name;
      logic  rst, st, ps, lu, go;
      int    hold;
      int    e_stage;
      logic  e_draw, e_tick;
      int    e_count;
      logic  e_max;
   } vec_t;

   vec_t vecs[14];
   vec_t sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic setv(input int i, input string n, input logic rst, st, ps, lu, go,
                       input int hold, input int es, input logic ed, et,
                       input int ec, input logic em);
      vecs[i].name = n;  vecs[i].rst = rst; vecs[i].st = st; vecs[i].ps = ps;
      vecs[i].lu = lu;   vecs[i].go = go;   vecs[i].hold = hold;
      vecs[i].e_stage = es; vecs[i].e_draw = ed; vecs[i].e_tick = et;
      vecs[i].e_count = ec; vecs[i].e_max = em;
   endtask

   task automatic check_outs(input string n, input int es, input logic ed, et,
                             input int ec, input logic em);
      check({n, ".rstage"},      64'(rstage),      64'(es));
      check({n, ".isDrawing"},   64'(isDrawing),   64'(ed));
      check({n, ".frame_tick"},  64'(frame_tick),  64'(et));
      check({n, ".frame_count"}, 64'(frame_count), 64'(ec));
      check({n, ".stage_max"},   64'(stage_max),   64'(em));
   endtask

   // Starts on the sample right after a frame boundary (first draw cycle)
   // and ends on the sample where the next frame_tick is seen.
   task automatic measure_frame(input logic lu, output int hi, output int lo);
      hi = 0;
      lo = 0;
      level_up = lu;
      while (isDrawing && hi < 100) begin
         hi++;
         @(negedge clock);
         level_up = 1'b0;
      end
      while (!frame_tick && lo < 100) begin
         lo++;
         @(negedge clock);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, lo, cyc, n;
      int exp_hi[4] = '{8, 6, 5, 5};
      int exp_st[4] = '{4, 5, 5, 5};
      logic exp_mx[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      vec_t v;

      //      idx name      rst st ps lu go hold stage draw tick count max
      setv(0,  "reset",     1, 0, 0, 0, 0, 2,   2, 0, 0, 0, 0);
      setv(1,  "start",     0, 1, 0, 0, 0, 1,   2, 1, 0, 0, 0);
      setv(2,  "draw9",     0, 0, 0, 0, 0, 9,   2, 1, 0, 0, 0);
      setv(3,  "blank0",    0, 0, 0, 0, 0, 1,   2, 0, 0, 0, 0);
      setv(4,  "blank1",    0, 0, 0, 0, 0, 1,   2, 0, 0, 0, 0);
      setv(5,  "tick1",     0, 0, 0, 0, 0, 1,   2, 1, 1, 1, 0);
      setv(6,  "draw1",     0, 0, 0, 0, 0, 1,   2, 1, 0, 1, 0);
      setv(7,  "lvlup",     0, 0, 0, 1, 0, 1,   2, 1, 0, 1, 0);
      setv(8,  "draw9b",    0, 0, 0, 0, 0, 7,   2, 1, 0, 1, 0);
      setv(9,  "blankb",    0, 0, 0, 0, 0, 1,   2, 0, 0, 1, 0);
      setv(10, "tick2",     0, 0, 0, 0, 0, 2,   3, 1, 1, 2, 0);
      setv(11, "draw8",     0, 0, 0, 0, 0, 7,   3, 1, 0, 2, 0);
      setv(12, "blankc",    0, 0, 0, 0, 0, 1,   3, 0, 0, 2, 0);
      setv(13, "tick3",     0, 0, 0, 0, 0, 2,   3, 1, 1, 3, 0);

      @(negedge clock);
      for (int i = 0; i < 14; i++) begin
         reset = vecs[i].rst; start = vecs[i].st; pause = vecs[i].ps;
         level_up = vecs[i].lu; game_over = vecs[i].go;
         sb.push_back(vecs[i]);
         repeat (vecs[i].hold) @(negedge clock);
         v = sb.pop_front();
         check_outs(v.name, v.e_stage, v.e_draw, v.e_tick, v.e_count, v.e_max);
      end

      // Level-up every frame: windows shrink to the floor, stage saturates.
      for (int i = 0; i < 4; i++) begin
         measure_frame(1'b1, hi, lo);
         check("sat.window", 64'(hi), 64'(exp_hi[i]));
         check("sat.blank", 64'(lo), 64'(2));
         check("sat.rstage", 64'(rstage), 64'(exp_st[i]));
         check("sat.stage_max", 64'(stage_max), 64'(exp_mx[i]));
      end

      // Pause for 3 cycles inside a 5-cycle window: tick arrives 3 cycles late.
      cyc = 0;
      do begin
         pause = (cyc >= 1 && cyc <= 3);
         @(negedge clock);
         cyc++;
         if (cyc >= 2 && cyc <= 4) check("pause.low", 64'(isDrawing), 64'(0));
         if (cyc == 5) check("pause.resume", 64'(isDrawing), 64'(1));
      end while (!frame_tick && cyc < 100);
      pause = 1'b0;
      check("pause.tick_delay", 64'(cyc), 64'(10));
      check("pause.frame_count", 64'(frame_count), 64'(8));

      // Game over from the top stage, then again mid-draw at stage 4.
      game_over = 1'b1;
      @(negedge clock);
      game_over = 1'b0;
      check_outs("go1", 2, 0, 0, 0, 0);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("go1.restart", 64'(isDrawing), 64'(1));
      measure_frame(1'b1, hi, lo);
      check("go.win_s2", 64'(hi), 64'(10));
      measure_frame(1'b1, hi, lo);
      check("go.win_s3", 64'(hi), 64'(8));
      check("go.rstage4", 64'(rstage), 64'(4));
      repeat (2) @(negedge clock);
      game_over = 1'b1;
      level_up = 1'b1;
      @(negedge clock);
      game_over = 1'b0;
      level_up = 1'b0;
      check_outs("go2", 2, 0, 0, 0, 0);
      level_up = 1'b1;
      pause = 1'b1;
      repeat (3) @(negedge clock);
      level_up = 1'b0;
      pause = 1'b0;
      check("idle.isDrawing", 64'(isDrawing), 64'(0));
      check("idle.frame_count", 64'(frame_count), 64'(0));

      // Reset during blank together with a level-up request.
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      measure_frame(1'b0, hi, lo);
      check("rst.win_a", 64'(hi), 64'(10));
      check("rst.idle_lu_ignored", 64'(rstage), 64'(2));
      measure_frame(1'b1, hi, lo);
      check("rst.rstage3", 64'(rstage), 64'(3));
      n = 0;
      while (isDrawing && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("rst.win_before", 64'(n), 64'(8));
      reset = 1'b1;
      level_up = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      level_up = 1'b0;
      check_outs("rst", 2, 0, 0, 0, 0);
      @(negedge clock);
      check("rst.idle", 64'(isDrawing), 64'(0));
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      measure_frame(1'b0, hi, lo);
      check("rst.win_after", 64'(hi), 64'(10));
      check("rst.rstage_after", 64'(rstage), 64'(2));
      check("rst.count_after", 64'(frame_count), 64'(1));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
